// File: rtl/cordic_iter_engine_if.sv
// Operand/result handshake bundle for the iterative CORDIC engine.
// It also carries the shared arctan/arctanh table port pair.
// slave is the engine side and master is the requester/table side.
interface cordic_iter_engine_if #(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 16
);
  localparam int p_IDX_W = $clog2(p_ITER);

  logic                      i_valid;
  logic                      o_ready;
  logic signed [p_WIDTH-1:0] i_x;
  logic signed [p_WIDTH-1:0] i_y;
  logic signed [p_WIDTH-1:0] i_z;
  logic                      i_mode;
  logic                      i_vectoring;

  logic [p_IDX_W-1:0]        o_lut_idx;
  logic                      o_lut_mode;
  logic signed [p_WIDTH-1:0] i_lut;

  logic                      o_valid;
  logic                      i_ready;
  logic signed [p_WIDTH-1:0] o_x;
  logic signed [p_WIDTH-1:0] o_y;
  logic signed [p_WIDTH-1:0] o_z;

  modport slave (
    input  i_valid, i_x, i_y, i_z, i_mode, i_vectoring, i_lut, i_ready,
    output o_ready, o_lut_idx, o_lut_mode, o_valid, o_x, o_y, o_z
  );

  modport master (
    output i_valid, i_x, i_y, i_z, i_mode, i_vectoring, i_lut, i_ready,
    input  o_ready, o_lut_idx, o_lut_mode, o_valid, o_x, o_y, o_z
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative multi-mode CORDIC engine.
// A single micro-rotation datapath is reused once per cycle.
// It supports circular and hyperbolic coordinates, each in rotation or vectoring mode.
// Hyperbolic shifts 4, 13 and 40 run twice so that the iteration converges.
// The angle table is external and is addressed by the registered shift amount and mode.
module cordic_iter_engine #(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cordic_iter_engine_if.slave  bus
);
  localparam int p_IDX_W = $clog2(p_ITER);
  localparam logic [p_IDX_W-1:0] LAST_S = p_IDX_W'(p_ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                    state_q;
  logic signed [p_WIDTH-1:0] x_q;
  logic signed [p_WIDTH-1:0] y_q;
  logic signed [p_WIDTH-1:0] z_q;
  logic                      mode_q;
  logic                      vec_q;
  logic                      rep_q;
  logic                      valid_q;
  logic [p_IDX_W-1:0]        s_q;

  logic signed [p_WIDTH-1:0] x_sh;
  logic signed [p_WIDTH-1:0] y_sh;
  logic signed [p_WIDTH-1:0] lut;
  logic signed [p_WIDTH-1:0] x_nx;
  logic signed [p_WIDTH-1:0] y_nx;
  logic signed [p_WIDTH-1:0] z_nx;
  logic [31:0]               s_wide;
  logic                      dir;
  logic                      is_rep_shift;
  logic                      repeat_now;
  logic                      last_iter;

  // Micro-rotation datapath: every update uses the values held before this cycle.
  always_comb begin
    x_sh   = x_q >>> s_q;
    y_sh   = y_q >>> s_q;
    lut    = bus.i_lut;
    dir    = vec_q ? y_q[p_WIDTH-1] : ~z_q[p_WIDTH-1];
    x_nx   = x_q;
    y_nx   = y_q;
    z_nx   = z_q;
    if (mode_q) begin
      if (dir) begin
        x_nx = x_q - y_sh;
        y_nx = y_q + x_sh;
        z_nx = z_q - lut;
      end else begin
        x_nx = x_q + y_sh;
        y_nx = y_q - x_sh;
        z_nx = z_q + lut;
      end
    end else begin
      if (dir) begin
        x_nx = x_q + y_sh;
        y_nx = y_q + x_sh;
        z_nx = z_q - lut;
      end else begin
        x_nx = x_q - y_sh;
        y_nx = y_q - x_sh;
        z_nx = z_q + lut;
      end
    end
  end

  // Shift schedule: decides whether the current hyperbolic shift is repeated and whether this is the last iteration.
  always_comb begin
    s_wide       = 32'(s_q);
    is_rep_shift = !mode_q && (s_wide == 32'd4 || s_wide == 32'd13 || s_wide == 32'd40);
    repeat_now   = is_rep_shift && !rep_q;
    last_iter    = (s_q == LAST_S) && !repeat_now;
  end

  // Control FSM: accept operands, iterate, then hold the result until downstream takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      vec_q   <= 1'b0;
      rep_q   <= 1'b0;
      valid_q <= 1'b0;
      s_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            x_q     <= bus.i_x;
            y_q     <= bus.i_y;
            z_q     <= bus.i_z;
            mode_q  <= bus.i_mode;
            vec_q   <= bus.i_vectoring;
            rep_q   <= 1'b0;
            s_q     <= bus.i_mode ? '0 : p_IDX_W'(1);
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          if (last_iter) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (repeat_now) begin
            rep_q <= 1'b1;
          end else begin
            rep_q <= 1'b0;
            s_q   <= s_q + p_IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready    = (state_q == IDLE) && !i_rst;
  assign bus.o_valid    = valid_q && !i_rst;
  assign bus.o_x        = x_q;
  assign bus.o_y        = y_q;
  assign bus.o_z        = z_q;
  assign bus.o_lut_idx  = s_q;
  assign bus.o_lut_mode = mode_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard testbench for cordic_iter_engine.
// It uses 16-bit Q2.14 operands with 1.0 = 16384.
// The reference LUT and a CORDIC reference model built from real math are kept inside the bench.
module tb_cordic_iter_engine;
  localparam int W = 16;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  cordic_iter_engine_if #(.p_WIDTH(W), .p_ITER(N)) bus ();

  cordic_iter_engine #(.p_WIDTH(W), .p_ITER(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    int acc;
    int run;
    bit apx;
    bit apz;
    int ax;
    int ay;
    int az;
  } exp_t;

  exp_t sb[$];
  int   circ_sched[$];
  int   hyp_sched[$];

  bit pend_apx = 0;
  bit pend_apz = 0;
  int pend_ax = 0;
  int pend_ay = 0;
  int pend_az = 0;

  // Free-running clock and edge counter used to measure latency.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference angle table: atan(2^-s) for circular mode and atanh(2^-s) for hyperbolic mode, in Q2.14.
  function automatic logic signed [W-1:0] lutVal(input bit mode, input int s);
    real t;
    real a;
    t = 1.0 / (2.0 ** s);
    if (mode) a = $atan(t);
    else if (s == 0) a = 0.0;
    else a = $atanh(t);
    return 16'($rtoi(a * 16384.0 + 0.5));
  endfunction

  // The external table answers combinationally from the engine's index and mode.
  always_comb bus.i_lut = lutVal(bus.o_lut_mode, int'(bus.o_lut_idx));

  // Reference CORDIC: apply the micro-rotation rules over the full shift schedule.
  function automatic void cordicRef(input bit mode, input bit vec,
                                    input logic signed [W-1:0] x0, y0, z0,
                                    output logic signed [W-1:0] xr, yr, zr);
    logic signed [W-1:0] x, y, z, xs, ys, lv;
    bit d;
    int n;
    x = x0; y = y0; z = z0;
    n = mode ? circ_sched.size() : hyp_sched.size();
    for (int k = 0; k < n; k++) begin
      int s;
      s  = mode ? circ_sched[k] : hyp_sched[k];
      xs = x >>> s;
      ys = y >>> s;
      lv = lutVal(mode, s);
      d  = vec ? (y < 0) : (z >= 0);
      if (mode) begin
        if (d) begin x = x - ys; y = y + xs; z = z - lv; end
        else   begin x = x + ys; y = y - xs; z = z + lv; end
      end else begin
        if (d) begin x = x + ys; y = y + xs; z = z - lv; end
        else   begin x = x - ys; y = y - xs; z = z + lv; end
      end
    end
    xr = x; yr = y; zr = z;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: pushes the expectation on every accept and checks every delivered result.
  int  rise_cyc = 0;
  bit  prev_valid = 0;
  int  last_acc = -1;
  int  last_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_valid = 0;
      last_acc = -1;
    end else begin
      if (bus.o_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = bus.o_valid;
      if (bus.o_valid && bus.i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_result: got x=%0d y=%0d z=%0d, expected no result", bus.o_x, bus.o_y, bus.o_z);
        end else begin
          e = sb.pop_front();
          checkOutput("res_x", int'(bus.o_x), int'(e.x), 0);
          checkOutput("res_y", int'(bus.o_y), int'(e.y), 0);
          checkOutput("res_z", int'(bus.o_z), int'(e.z), 0);
          checkOutput("latency", rise_cyc - e.acc, e.run, 0);
          if (e.apx) begin
            checkOutput("approx_x", int'(bus.o_x), e.ax, 8);
            checkOutput("approx_y", int'(bus.o_y), e.ay, 8);
            if (e.apz) checkOutput("approx_z", int'(bus.o_z), e.az, 8);
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        cordicRef(bus.i_mode, bus.i_vectoring, bus.i_x, bus.i_y, bus.i_z, e.x, e.y, e.z);
        e.acc = cyc + 1;
        e.run = bus.i_mode ? circ_sched.size() : hyp_sched.size();
        e.apx = pend_apx; e.apz = pend_apz;
        e.ax = pend_ax; e.ay = pend_ay; e.az = pend_az;
        pend_apx = 0;
        pend_apz = 0;
        if (last_acc >= 0) checkOutput("accept_spacing_ok", int'(e.acc - last_acc >= last_run + 2), 1, 0);
        last_acc = e.acc;
        last_run = e.run;
        sb.push_back(e);
      end
    end
  end

  task automatic setApprox(input bit apz, input int ax, input int ay, input int az);
    pend_apx = 1;
    pend_apz = apz;
    pend_ax = ax;
    pend_ay = ay;
    pend_az = az;
  endtask

  // Present one operand set and wait for the accept edge; optionally leave i_valid high.
  task automatic applyStimulus(input bit mode, input bit vec, input int x, input int y, input int z, input bit keep);
    int n;
    @(posedge clk);
    #1;
    bus.i_mode      = mode;
    bus.i_vectoring = vec;
    bus.i_x         = 16'(x);
    bus.i_y         = 16'(y);
    bus.i_z         = 16'(z);
    bus.i_valid     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_ready && n < 200);
    checkOutput("accept_in_time", int'(bus.o_ready), 1, 0);
    @(posedge clk);
    #1;
    if (!keep) bus.i_valid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.o_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", int'(n < limit), 1, 0);
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(2 * lim)) - lim;
  endfunction

  // Watchdog so that the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic signed [W-1:0] ex, ey, ez;
    int seen;
    for (int s = 0; s < N; s++) circ_sched.push_back(s);
    for (int s = 1; s < N; s++) begin
      hyp_sched.push_back(s);
      if (s == 4 || s == 13 || s == 40) hyp_sched.push_back(s);
    end

    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_x = '0; bus.i_y = '0; bus.i_z = '0;
    bus.i_mode = 1'b0; bus.i_vectoring = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", int'(bus.o_ready), 0, 0);
    checkOutput("reset_valid", int'(bus.o_valid), 0, 0);
    checkOutput("reset_x", int'(bus.o_x), 0, 0);
    checkOutput("reset_y", int'(bus.o_y), 0, 0);
    checkOutput("reset_z", int'(bus.o_z), 0, 0);
    checkOutput("reset_idx", int'(bus.o_lut_idx), 0, 0);
    checkOutput("reset_mode", int'(bus.o_lut_mode), 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", int'(bus.o_ready), 1, 0);

    // Circular rotation by pi/4.
    setApprox(1, 11585, 11585, 0);
    applyStimulus(1, 0, 9949, 0, 12868, 0);
    waitDrain(60);

    // Circular vectoring.
    setApprox(1, 19079, 0, 12868);
    applyStimulus(1, 1, 8192, 8192, 0, 0);
    waitDrain(60);

    // Hyperbolic rotation with the index sequence observed.
    setApprox(0, 18475, 8538, 0);
    applyStimulus(0, 0, 19784, 0, 8192, 0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      checkOutput("lut_idx", int'(bus.o_lut_idx), hyp_sched[k], 0);
      if (k == 0) checkOutput("lut_mode_hyp", int'(bus.o_lut_mode), 0, 0);
    end
    waitDrain(60);

    // Backpressure in DONE while new operands are pulsed.
    bus.i_ready = 1'b0;
    applyStimulus(1, 0, 7000, -3000, -9000, 0);
    cordicRef(1'b1, 1'b0, 16'sd7000, -16'sd3000, -16'sd9000, ex, ey, ez);
    seen = 0;
    while (!bus.o_valid && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("bp_valid_rose", int'(bus.o_valid), 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.i_valid = ~bus.i_valid;
      bus.i_mode  = 1'($urandom_range(1));
      bus.i_x = 16'(rnd(9000)); bus.i_y = 16'(rnd(9000)); bus.i_z = 16'(rnd(9000));
      @(negedge clk);
      checkOutput("bp_valid", int'(bus.o_valid), 1, 0);
      checkOutput("bp_ready", int'(bus.o_ready), 0, 0);
      checkOutput("bp_x_stable", int'(bus.o_x), int'(ex), 0);
      checkOutput("bp_y_stable", int'(bus.o_y), int'(ey), 0);
      checkOutput("bp_z_stable", int'(bus.o_z), int'(ez), 0);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_ready_after_xfer", int'(bus.o_ready), 1, 0);
    checkOutput("bp_valid_after_xfer", int'(bus.o_valid), 0, 0);
    checkOutput("bp_sb_empty", sb.size(), 0, 0);

    // Reset in the middle of RUN abandons the operation.
    applyStimulus(1, 0, 5000, 3000, 4000, 0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_x", int'(bus.o_x), 0, 0);
    checkOutput("midrst_y", int'(bus.o_y), 0, 0);
    checkOutput("midrst_z", int'(bus.o_z), 0, 0);
    checkOutput("midrst_valid", int'(bus.o_valid), 0, 0);
    checkOutput("midrst_ready", int'(bus.o_ready), 0, 0);
    checkOutput("midrst_idx", int'(bus.o_lut_idx), 0, 0);
    checkOutput("midrst_mode", int'(bus.o_lut_mode), 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1;
    end
    checkOutput("no_valid_after_abort", seen, 0, 0);
    setApprox(1, 11585, 11585, 0);
    applyStimulus(1, 0, 9949, 0, 12868, 0);
    waitDrain(60);

    // Back-to-back with i_valid held high across both operations.
    applyStimulus(1, 0, 6000, -2000, 5000, 1);
    applyStimulus(1, 1, 4000, 7000, 1000, 0);
    waitDrain(120);

    // Randomized operations with random downstream stalls.
    for (int t = 0; t < 24; t++) begin
      bus.i_ready = 1'($urandom_range(1));
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)),
                    rnd(12000), rnd(12000), rnd(16000), 0);
      if (!bus.i_ready) begin
        repeat ($urandom_range(18, 25)) @(posedge clk);
        #1 bus.i_ready = 1'b1;
      end
      waitDrain(80);
    end

    checkOutput("sb_empty_end", sb.size(), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
